// File: rtl/power_pkg.sv
// Shared types and sizing helpers for the multi-domain power sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package power_pkg;

  // Per-domain sequencer state. Up path: OFF..ON. Down path: ON..OFF. ERR is a trap.
  typedef enum logic [3:0] {
    S_OFF     = 4'd0,
    S_PWR_ON  = 4'd1,
    S_RESTORE = 4'd2,
    S_ISO_REL = 4'd3,
    S_ON      = 4'd4,
    S_CLK_OFF = 4'd5,
    S_ISO     = 4'd6,
    S_SAVE    = 4'd7,
    S_PWR_OFF = 4'd8,
    S_ERR     = 4'd9
  } pseq_state_t;

  // One counter serves both the timed steps and the ack timeout.
  // It must be able to hold the larger of the two limits.
  function automatic int cnt_width(input int step_cyc, input int ack_timeout);
    int m;
    m = (step_cyc > ack_timeout) ? step_cyc : ack_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/power_seq_ctrl_if.sv
// Bundle between power-management request logic and the per-domain power cells.
// Latency: n/a (wires only).
// Backpressure: pwr_ack is the only handshake; the sequencer waits on it.
//   master: drives pwr_req/pwr_ack, observes the controls.
//   slave : the sequencer; consumes pwr_req/pwr_ack, drives every control output.
interface power_seq_ctrl_if #(
  parameter int NUM_DOM = 4
);
  logic [NUM_DOM-1:0] pwr_req;
  logic [NUM_DOM-1:0] pwr_ack;
  logic [NUM_DOM-1:0] pwr_en;
  logic [NUM_DOM-1:0] iso_n;
  logic [NUM_DOM-1:0] clk_en;
  logic [NUM_DOM-1:0] save;
  logic [NUM_DOM-1:0] restore;
  logic [NUM_DOM-1:0] dom_on;
  logic [NUM_DOM-1:0] err;
  logic               busy;

  modport master (
    output pwr_req, pwr_ack,
    input  pwr_en, iso_n, clk_en, save, restore, dom_on, err, busy
  );

  modport slave (
    input  pwr_req, pwr_ack,
    output pwr_en, iso_n, clk_en, save, restore, dom_on, err, busy
  );

endinterface

// File: rtl/power_seq_dom.sv
// Single-domain power sequencer: clock gate, isolation, retention and switch ordering.
// Latency: outputs are registered decodes of the state, one cycle behind the state.
// Backpressure: PWR_ON/PWR_OFF stall on pwr_ack, bounded by ACK_TIMEOUT, then ERR.
//   Ports: ck/rn clock and async active-low reset; pwr_req/pwr_ack inputs;
//   pwr_en, iso_n, clk_en, save, restore, dom_on, err, busy registered outputs.
module power_seq_dom
  import power_pkg::*;
#(
  parameter int STEP_CYC    = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic ck,
  input  logic rn,
  input  logic pwr_req,
  input  logic pwr_ack,
  output logic pwr_en,
  output logic iso_n,
  output logic clk_en,
  output logic save,
  output logic restore,
  output logic dom_on,
  output logic err,
  output logic busy
);

  localparam int            CW        = cnt_width(STEP_CYC, ACK_TIMEOUT);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  pseq_state_t   state;
  logic [CW-1:0] cnt;

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state   <= S_OFF;
      cnt     <= '0;
      pwr_en  <= 1'b0;
      iso_n   <= 1'b0;
      clk_en  <= 1'b0;
      save    <= 1'b0;
      restore <= 1'b0;
      dom_on  <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // Outputs are cumulative along the sequence: each state keeps what
      // the earlier states of the same direction set or cleared.
      pwr_en  <= state inside {S_PWR_ON, S_RESTORE, S_ISO_REL, S_ON,
                               S_CLK_OFF, S_ISO, S_SAVE};
      iso_n   <= state inside {S_ISO_REL, S_ON, S_CLK_OFF};
      clk_en  <= (state == S_ON);
      dom_on  <= (state == S_ON);
      // Counter is zero only on the first cycle after entry, giving one-cycle pulses.
      restore <= (state == S_RESTORE) && (cnt == '0);
      save    <= (state == S_SAVE) && (cnt == '0);
      err     <= (state == S_ERR);
      busy    <= !(state inside {S_OFF, S_ON, S_ERR});

      // Saturating count; any state change below overrides with a clear.
      if (cnt != CNT_MAX) cnt <= cnt + CW'(1);

      case (state)
        S_OFF: begin
          if (pwr_req) begin
            state <= S_PWR_ON;
            cnt   <= '0;
          end
        end
        S_PWR_ON: begin
          if (pwr_ack) begin
            state <= S_RESTORE;
            cnt   <= '0;
          end else if (cnt >= TO_LAST) begin
            state <= S_ERR;
            cnt   <= '0;
          end
        end
        S_RESTORE: begin
          if (cnt >= STEP_LAST) begin
            state <= S_ISO_REL;
            cnt   <= '0;
          end
        end
        S_ISO_REL: begin
          if (cnt >= STEP_LAST) begin
            state <= S_ON;
            cnt   <= '0;
          end
        end
        S_ON: begin
          if (!pwr_req) begin
            state <= S_CLK_OFF;
            cnt   <= '0;
          end
        end
        S_CLK_OFF: begin
          if (cnt >= STEP_LAST) begin
            state <= S_ISO;
            cnt   <= '0;
          end
        end
        S_ISO: begin
          if (cnt >= STEP_LAST) begin
            state <= S_SAVE;
            cnt   <= '0;
          end
        end
        S_SAVE: begin
          if (cnt >= STEP_LAST) begin
            state <= S_PWR_OFF;
            cnt   <= '0;
          end
        end
        S_PWR_OFF: begin
          if (!pwr_ack) begin
            state <= S_OFF;
            cnt   <= '0;
          end else if (cnt >= TO_LAST) begin
            state <= S_ERR;
            cnt   <= '0;
          end
        end
        S_ERR: begin
          // Leave only once the request is withdrawn and the rail is seen down.
          if (!pwr_req && !pwr_ack) begin
            state <= S_OFF;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/power_seq_ctrl.sv
// Multi-domain power sequencer: NUM_DOM independent copies of power_seq_dom.
// Latency: request sampled at edge t changes the first output at edge t+1.
// Backpressure: each domain waits on its own pwr_ack; domains never stall each other.
//   Ports: ck clock, rn async active-low reset, bus (slave side of power_seq_ctrl_if).
module power_seq_ctrl
  import power_pkg::*;
#(
  parameter int NUM_DOM     = 4,
  parameter int STEP_CYC    = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              ck,
  input  logic              rn,
  power_seq_ctrl_if.slave   bus
);

  logic [NUM_DOM-1:0] pwr_en;
  logic [NUM_DOM-1:0] iso_n;
  logic [NUM_DOM-1:0] clk_en;
  logic [NUM_DOM-1:0] save;
  logic [NUM_DOM-1:0] restore;
  logic [NUM_DOM-1:0] dom_on;
  logic [NUM_DOM-1:0] err;
  logic [NUM_DOM-1:0] dom_busy;

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    power_seq_dom #(
      .STEP_CYC    (STEP_CYC),
      .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_dom (
      .ck      (ck),
      .rn      (rn),
      .pwr_req (bus.pwr_req[g]),
      .pwr_ack (bus.pwr_ack[g]),
      .pwr_en  (pwr_en[g]),
      .iso_n   (iso_n[g]),
      .clk_en  (clk_en[g]),
      .save    (save[g]),
      .restore (restore[g]),
      .dom_on  (dom_on[g]),
      .err     (err[g]),
      .busy    (dom_busy[g])
    );
  end

  assign bus.pwr_en  = pwr_en;
  assign bus.iso_n   = iso_n;
  assign bus.clk_en  = clk_en;
  assign bus.save    = save;
  assign bus.restore = restore;
  assign bus.dom_on  = dom_on;
  assign bus.err     = err;
  // OR of per-domain registered terms, so it clears with the domains on reset.
  assign bus.busy    = |dom_busy;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Directed bench for power_seq_ctrl with STEP_CYC=2, ACK_TIMEOUT=8.
// Per-edge expected vectors: {pwr_en,iso_n,clk_en,save,restore,dom_on,err,busy}.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_power_seq_ctrl;

  localparam int ND = 4;

  logic ck;
  logic rn;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] exp_q[$];

  power_seq_ctrl_if #(.NUM_DOM(ND)) bus ();

  power_seq_ctrl #(
    .NUM_DOM     (ND),
    .STEP_CYC    (2),
    .ACK_TIMEOUT (8)
  ) dut (
    .ck  (ck),
    .rn  (rn),
    .bus (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dom_vec(input int d);
    return {bus.pwr_en[d], bus.iso_n[d], bus.clk_en[d], bus.save[d],
            bus.restore[d], bus.dom_on[d], bus.err[d], bus.busy};
  endfunction

  // Expected power-up trace when req is sampled at edge 0 and ack at edge a.
  function automatic logic [7:0] up_vec(input int k, input int a);
    if (k == 0)          return 8'h00;
    else if (k <= a)     return 8'h81;
    else if (k == a + 1) return 8'h89;
    else if (k == a + 2) return 8'h81;
    else if (k <= a + 4) return 8'hC1;
    else                 return 8'hE4;
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pwr_en"},  bus.pwr_en,  '0);
    chk({tag, " iso_n"},   bus.iso_n,   '0);
    chk({tag, " clk_en"},  bus.clk_en,  '0);
    chk({tag, " save"},    bus.save,    '0);
    chk({tag, " restore"}, bus.restore, '0);
    chk({tag, " dom_on"},  bus.dom_on,  '0);
    chk({tag, " err"},     bus.err,     '0);
    chk({tag, " busy"},    bus.busy,    '0);
  endtask

  // Drive up to two req changes and one ack change at given edge indices
  // (-1 = unused) on domain d, checking exp_q[k] after every edge k.
  task automatic run_seq(input string name, input int d,
                         input int rk1, input logic rv1,
                         input int rk2, input logic rv2,
                         input int ak,  input logic av);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == rk1) bus.pwr_req[d] = rv1;
      if (k == rk2) bus.pwr_req[d] = rv2;
      if (k == ak)  bus.pwr_ack[d] = av;
      tick();
      chk($sformatf("%s d%0d k%0d", name, d, k), dom_vec(d), exp_q[k]);
    end
  endtask

  initial begin
    logic [7:0] e0, e2, v;

    // Reset: outputs held at zero during and after reset with no requests.
    rn = 1'b0;
    bus.pwr_req = '0;
    bus.pwr_ack = '0;
    repeat (3) tick();
    chk_all_zero("in_reset");
    #2 rn = 1'b1;
    repeat (3) tick();
    chk_all_zero("post_reset");

    // Power-up domain 0, ack at edge 4.
    exp_q.delete();
    for (int k = 0; k <= 10; k++) exp_q.push_back(up_vec(k, 4));
    run_seq("pwr_up", 0, 0, 1'b1, -1, 1'b0, 4, 1'b1);

    // Power-down domain 0 from ON, ack drops at edge 8.
    exp_q = '{8'hE4, 8'hC1, 8'hC1, 8'h81, 8'h81, 8'h91, 8'h81, 8'h01, 8'h01, 8'h00};
    run_seq("pwr_dn", 0, 0, 1'b0, -1, 1'b0, 8, 1'b0);

    // Ack timeout on domain 1, request withdrawn at edge 10.
    exp_q = '{8'h00, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81,
              8'h02, 8'h02, 8'h00, 8'h00};
    run_seq("timeout", 1, 0, 1'b1, 10, 1'b0, -1, 1'b0);

    // Request drops during ISO_REL on domain 3: ON still reached, then power-down.
    exp_q = '{8'h00, 8'h81, 8'h89, 8'h81, 8'hC1, 8'hC1, 8'hE4, 8'hC1, 8'hC1, 8'h81};
    run_seq("mid_drop", 3, 0, 1'b1, 4, 1'b0, 1, 1'b1);

    // Asynchronous reset mid power-down: zero before any clock edge.
    rn = 1'b0;
    #1;
    chk_all_zero("async_rst_a");
    bus.pwr_req = '0;
    bus.pwr_ack = '0;
    #2 rn = 1'b1;
    tick();

    // Domains 0 and 2 concurrently, acks at edges 4 and 2.
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) begin
        bus.pwr_req[0] = 1'b1;
        bus.pwr_req[2] = 1'b1;
      end
      if (k == 2) bus.pwr_ack[2] = 1'b1;
      if (k == 4) bus.pwr_ack[0] = 1'b1;
      tick();
      e0 = up_vec(k, 4);
      e2 = up_vec(k, 2);
      v = dom_vec(0);
      chk($sformatf("conc d0 k%0d", k), v[7:1], e0[7:1]);
      v = dom_vec(2);
      chk($sformatf("conc d2 k%0d", k), v[7:1], e2[7:1]);
      v = dom_vec(1);
      chk($sformatf("conc d1 k%0d", k), v[7:1], 7'd0);
      v = dom_vec(3);
      chk($sformatf("conc d3 k%0d", k), v[7:1], 7'd0);
      chk($sformatf("conc busy k%0d", k), bus.busy, e0[0] | e2[0]);
    end

    // Power-down domain 0 while domain 2 stays ON, reset during SAVE.
    exp_q = '{8'hE4, 8'hC1, 8'hC1, 8'h81, 8'h81, 8'h91};
    run_seq("dn_save", 0, 0, 1'b0, -1, 1'b0, -1, 1'b0);
    v = dom_vec(2);
    chk("dn_save d2 on", v, 8'hE4 | 8'h01);
    rn = 1'b0;
    #1;
    chk_all_zero("async_rst_save");
    bus.pwr_req = '0;
    bus.pwr_ack = '0;
    #2 rn = 1'b1;
    repeat (4) tick();
    chk_all_zero("no_resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
